implies_op_scheduler: RTL and testbench



---
 rtl/implies_sched_pkg.sv | 18 +
 rtl/implies_unit.sv | 12 +
 rtl/implies_op_scheduler.sv | 179 +++++++++++++++++
 tb/tb_implies_op_scheduler.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/implies_sched_pkg.sv
// Shared types and constants for the implication-unit scheduler.
// The SWEEP state is only reachable when IMPLIES_SELFTEST_EN is defined.
package implies_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        RESP  = 2'd2,
        SWEEP = 2'd3
    } sched_state_t;

    localparam logic CLIENT0 = 1'b0;
    localparam logic CLIENT1 = 1'b1;

    // Pointing at client 1 after reset hands the first tie to client 0.
    localparam logic LAST_GRANT_RST = CLIENT1;

endpackage

// File: rtl/implies_unit.sv
// Combinational bitwise implication y = ~a | b; the only place the operation is computed.
module implies_unit #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    assign y = ~a | b;

endmodule

// File: rtl/implies_op_scheduler.sv
// Two-client round-robin scheduler sharing one implies_unit over valid/ready channels.
// Optional self-test sweep compiled in with IMPLIES_SELFTEST_EN.
module implies_op_scheduler
    import implies_sched_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_y,
    output logic             busy
`ifdef IMPLIES_SELFTEST_EN
    ,
    input  logic             st_start,
    output logic             st_done,
    output logic             st_pass
`endif
);

    sched_state_t     state;
    logic             last_grant;
    logic             grant0;
    logic             grant1;
    logic             accept0;
    logic             accept1;
    logic             st_block;
    logic [WIDTH-1:0] a_p0;
    logic [WIDTH-1:0] b_p0;
    logic             id_p0;
    logic [WIDTH-1:0] unit_a;
    logic [WIDTH-1:0] unit_b;
    logic [WIDTH-1:0] unit_y;

    // On a tie the client that was not served last wins.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (req0_valid && req1_valid) begin
            grant0 = (last_grant == CLIENT1);
            grant1 = (last_grant == CLIENT0);
        end else begin
            grant0 = req0_valid;
            grant1 = req1_valid;
        end
    end

`ifdef IMPLIES_SELFTEST_EN
    logic [2*WIDTH-1:0] st_cnt;
    logic               st_err;
    logic               st_mismatch;

    function automatic logic [WIDTH-1:0] ref_implies(input logic [WIDTH-1:0] a,
                                                     input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) begin
            r[i] = (a[i] == 1'b0) || (b[i] == 1'b1);
        end
        return r;
    endfunction

    // A starting sweep takes precedence over any request seen in the same cycle.
    assign st_block    = st_start;
    assign unit_a      = (state == SWEEP) ? st_cnt[2*WIDTH-1:WIDTH] : a_p0;
    assign unit_b      = (state == SWEEP) ? st_cnt[WIDTH-1:0] : b_p0;
    assign st_mismatch = (unit_y != ref_implies(unit_a, unit_b));
`else
    assign st_block = 1'b0;
    assign unit_a   = a_p0;
    assign unit_b   = b_p0;
`endif

    assign req0_ready = (state == IDLE) && grant0 && !st_block;
    assign req1_ready = (state == IDLE) && grant1 && !st_block;
    assign accept0    = req0_valid && req0_ready;
    assign accept1    = req1_valid && req1_ready;

    implies_unit #(
        .WIDTH(WIDTH)
    ) u_implies_unit (
        .a(unit_a),
        .b(unit_b),
        .y(unit_y)
    );

    // Stage p0: operand capture on the accept edge.
    always_ff @(posedge clk) begin
        if (accept0) begin
            a_p0  <= req0_a;
            b_p0  <= req0_b;
            id_p0 <= CLIENT0;
        end else if (accept1) begin
            a_p0  <= req1_a;
            b_p0  <= req1_b;
            id_p0 <= CLIENT1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= LAST_GRANT_RST;
            rsp_valid  <= 1'b0;
            rsp_y      <= '0;
            rsp_id     <= CLIENT0;
            busy       <= 1'b0;
`ifdef IMPLIES_SELFTEST_EN
            st_cnt     <= '0;
            st_err     <= 1'b0;
            st_done    <= 1'b0;
            st_pass    <= 1'b0;
`endif
        end else begin
`ifdef IMPLIES_SELFTEST_EN
            st_done <= 1'b0;
`endif
            case (state)
                IDLE: begin
`ifdef IMPLIES_SELFTEST_EN
                    if (st_start) begin
                        state   <= SWEEP;
                        busy    <= 1'b1;
                        st_cnt  <= '0;
                        st_err  <= 1'b0;
                        st_pass <= 1'b0;
                    end else
`endif
                    if (accept0 || accept1) begin
                        last_grant <= accept0 ? CLIENT0 : CLIENT1;
                        state      <= EXEC;
                        busy       <= 1'b1;
                    end
                end
                // Stage p1: result registered into the response holding register.
                EXEC: begin
                    rsp_y     <= unit_y;
                    rsp_id    <= id_p0;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
`ifdef IMPLIES_SELFTEST_EN
                SWEEP: begin
                    st_err <= st_err | st_mismatch;
                    if (st_cnt == '1) begin
                        st_done <= 1'b1;
                        st_pass <= !(st_err || st_mismatch);
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        st_cnt <= st_cnt + 1'b1;
                    end
                end
`endif
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_implies_op_scheduler.sv
// Self-checking bench for implies_op_scheduler: directed scenarios plus a randomized
// run against a transaction-level reference model.
module tb_implies_op_scheduler;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_y;
    logic             busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    implies_op_scheduler #(
        .WIDTH(WIDTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req0_valid(req0_valid),
        .req0_ready(req0_ready),
        .req0_a(req0_a),
        .req0_b(req0_b),
        .req1_valid(req1_valid),
        .req1_ready(req1_ready),
        .req1_a(req1_a),
        .req1_b(req1_b),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_id(rsp_id),
        .rsp_y(rsp_y),
        .busy(busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_a     = '0;
        req0_b     = '0;
        req1_a     = '0;
        req1_b     = '0;
        rsp_ready  = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        checks++; if (rsp_y !== 4'b0000) begin errors++; $display("FAIL reset_rsp_y: got %b want 0000", rsp_y); end
        checks++; if (rsp_id !== 1'b0) begin errors++; $display("FAIL reset_rsp_id: got %b want 0", rsp_id); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        req1_valid = 1'b1;
        #1;
        checks++; if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin errors++; $display("FAIL reset_solo1_ready: got r0=%b r1=%b want r0=0 r1=1", req0_ready, req1_ready); end
        req0_valid = 1'b1;
        #1;
        checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin errors++; $display("FAIL reset_tie_ready: got r0=%b r1=%b want r0=1 r1=0", req0_ready, req1_ready); end
        // Withdraw both before any edge: no operation may start.
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_withdraw_busy: got %b want 0", busy); end
    endtask

    task automatic test_single();
        do_reset();
        req0_valid = 1'b1;
        req0_a     = 4'b1100;
        req0_b     = 4'b1010;
        #1;
        checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL single_ready: got %b want 1", req0_ready); end
        step();
        req0_valid = 1'b0;
        #1;
        checks++; if (rsp_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL single_exec: got valid=%b busy=%b want valid=0 busy=1", rsp_valid, busy); end
        step();
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL single_rsp_valid: got %b want 1", rsp_valid); end
        checks++; if (rsp_y !== 4'b1011) begin errors++; $display("FAIL single_rsp_y: got %b want 1011", rsp_y); end
        checks++; if (rsp_id !== 1'b0) begin errors++; $display("FAIL single_rsp_id: got %b want 0", rsp_id); end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_release: got valid=%b busy=%b want 0 0", rsp_valid, busy); end
    endtask

    task automatic test_both();
        do_reset();
        req0_valid = 1'b1; req0_a = 4'b0000; req0_b = 4'b0000;
        req1_valid = 1'b1; req1_a = 4'b1111; req1_b = 4'b0101;
        #1;
        checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin errors++; $display("FAIL both_first_grant: got r0=%b r1=%b want 1 0", req0_ready, req1_ready); end
        step();
        checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin errors++; $display("FAIL both_exec_ready: got r0=%b r1=%b want 0 0", req0_ready, req1_ready); end
        step();
        checks++; if (rsp_valid !== 1'b1 || rsp_y !== 4'b1111 || rsp_id !== 1'b0) begin errors++; $display("FAIL both_rsp0: got v=%b y=%b id=%b want 1 1111 0", rsp_valid, rsp_y, rsp_id); end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        #1;
        checks++; if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin errors++; $display("FAIL both_second_grant: got r0=%b r1=%b want 0 1", req0_ready, req1_ready); end
        step();
        step();
        checks++; if (rsp_valid !== 1'b1 || rsp_y !== 4'b0101 || rsp_id !== 1'b1) begin errors++; $display("FAIL both_rsp1: got v=%b y=%b id=%b want 1 0101 1", rsp_valid, rsp_y, rsp_id); end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        #1;
        checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin errors++; $display("FAIL both_alternate: got r0=%b r1=%b want 1 0", req0_ready, req1_ready); end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        step();
    endtask

    task automatic test_backpressure();
        do_reset();
        req1_valid = 1'b1; req1_a = 4'b0011; req1_b = 4'b0000;
        step();
        req1_valid = 1'b0;
        // rsp_ready asserted while still in EXEC must be ignored.
        rsp_ready = 1'b1;
        step();
        rsp_ready  = 1'b0;
        req0_valid = 1'b1; req0_a = 4'b0110; req0_b = 4'b0001;
        req1_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (rsp_valid !== 1'b1 || rsp_y !== 4'b1100 || rsp_id !== 1'b1) begin errors++; $display("FAIL bp_hold[%0d]: got v=%b y=%b id=%b want 1 1100 1", i, rsp_valid, rsp_y, rsp_id); end
            checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin errors++; $display("FAIL bp_ready[%0d]: got r0=%b r1=%b want 0 0", i, req0_ready, req1_ready); end
            step();
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_release: got %b want 0", rsp_valid); end
        checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin errors++; $display("FAIL bp_next_grant: got r0=%b r1=%b want 1 0", req0_ready, req1_ready); end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        step();
    endtask

    task automatic test_reset_in_exec();
        do_reset();
        req0_valid = 1'b1; req0_a = 4'b0001; req0_b = 4'b0000;
        step();
        req0_valid = 1'b0;
        rst        = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL rexec_after: got busy=%b valid=%b want 0 0", busy, rsp_valid); end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rexec_no_rsp[%0d]: got %b want 0", i, rsp_valid); end
        end
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin errors++; $display("FAIL rexec_grant: got r0=%b r1=%b want 1 0", req0_ready, req1_ready); end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        step();
    endtask

    // Transaction-level model: each client holds one pending operation until it
    // is accepted; a single operation is in flight and is answered one cycle after
    // it leaves the accept cycle.
    task automatic test_random();
        logic             pend [2];
        logic [WIDTH-1:0] pa   [2];
        logic [WIDTH-1:0] pb   [2];
        int               issued   [2];
        int               last_served;
        logic             in_flight;
        int               age;
        int               exp_id;
        logic [WIDTH-1:0] exp_y;
        int               served;
        int               accepted;
        int               cyc;
        int               g;
        logic             exp_r0, exp_r1, exp_v, took;

        do_reset();
        pend[0] = 1'b0; pend[1] = 1'b0;
        issued[0] = 0; issued[1] = 0;
        last_served = 1;
        in_flight   = 1'b0;
        age = 0; exp_id = 0; exp_y = '0;
        served = 0; accepted = 0; cyc = 0;

        while (served < 500 && cyc < 20000) begin
            for (int c = 0; c < 2; c++) begin
                if (!pend[c] && $urandom_range(0, 2) != 0) begin
                    pend[c] = 1'b1;
                    pa[c]   = WIDTH'($urandom);
                    pb[c]   = WIDTH'($urandom);
                    issued[c]++;
                end
            end
            req0_valid = pend[0]; req0_a = pa[0]; req0_b = pb[0];
            req1_valid = pend[1]; req1_a = pa[1]; req1_b = pb[1];
            rsp_ready  = ($urandom_range(0, 3) != 0);
            #1;
            g = -1;
            if (pend[0] && pend[1]) g = (last_served == 1) ? 0 : 1;
            else if (pend[0])        g = 0;
            else if (pend[1])        g = 1;
            exp_r0 = !in_flight && (g == 0);
            exp_r1 = !in_flight && (g == 1);
            exp_v  = in_flight && (age >= 1);
            checks++; if (req0_ready !== exp_r0 || req1_ready !== exp_r1) begin errors++; $display("FAIL rand_ready cyc %0d: got r0=%b r1=%b want r0=%b r1=%b", cyc, req0_ready, req1_ready, exp_r0, exp_r1); end
            checks++; if (rsp_valid !== exp_v) begin errors++; $display("FAIL rand_rsp_valid cyc %0d: got %b want %b", cyc, rsp_valid, exp_v); end
            took = exp_v && rsp_ready;
            if (took) begin
                checks++; if (rsp_y !== exp_y || rsp_id !== exp_id[0]) begin errors++; $display("FAIL rand_rsp cyc %0d: got y=%b id=%b want y=%b id=%0d", cyc, rsp_y, rsp_id, exp_y, exp_id); end
                served++;
            end
            step();
            if (took) in_flight = 1'b0;
            else if (in_flight) age++;
            if (!exp_v && !in_flight && g >= 0 && !took) begin
                in_flight   = 1'b1;
                age         = 0;
                exp_id      = g;
                exp_y       = ~pa[g] | pb[g];
                pend[g]     = 1'b0;
                last_served = g;
                accepted++;
            end
            cyc++;
        end
        checks++; if (served != 500) begin errors++; $display("FAIL rand_served: got %0d want 500 within budget", served); end
        checks++; if (accepted != served + (in_flight ? 1 : 0)) begin errors++; $display("FAIL rand_accounting: accepted %0d served %0d", accepted, served); end
        checks++; if (issued[0] + issued[1] != accepted + (pend[0] ? 1 : 0) + (pend[1] ? 1 : 0)) begin errors++; $display("FAIL rand_lost: issued %0d accepted %0d", issued[0] + issued[1], accepted); end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready  = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_both();
        test_backpressure();
        test_reset_in_exec();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
